// File: rtl/ram_responder.sv
// ram_responder: backing-memory model for the cache line-fill / write-back interface.
// Ports:
//   i_clk, i_reset_n   clock and synchronous active-low reset
//   i_rdram, i_wrram   level line read / write requests, held until o_ram_ack
//   i_addr, i_wdata    line address and write-back line, sampled at acceptance
//   o_rdata            fill line, valid in the ack cycle and held until the next read completes
//   o_ram_ack          one-cycle completion pulse
//   o_busy             high from acceptance until the serviced request is released
//   o_rd_cnt, o_wr_cnt saturating counts of completed reads / writes
module ram_responder #(
  parameter int ADDR_W  = 14,
  parameter int MEM_AW  = 8,
  parameter int DATA_W  = 64,
  parameter int LATENCY = 3
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_rdram,
  input  logic              i_wrram,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_ram_ack,
  output logic              o_busy,
  output logic [15:0]       o_rd_cnt,
  output logic [15:0]       o_wr_cnt
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_REL} state_t;
  state_t              r_state, w_next;
  logic                r_op_wr;
  logic [MEM_AW-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [3:0]          r_cnt;
  logic [DATA_W-1:0]   r_rdata;
  logic [15:0]         r_rd_cnt, r_wr_cnt;
  logic [DATA_W-1:0]   r_mem [2**MEM_AW];
  logic                w_req;
  logic                w_unused;
  // upper address bits alias onto the implemented depth
  assign w_unused = ^i_addr[ADDR_W-1:MEM_AW];
  // release is judged only on the request line of the op being serviced
  assign w_req = r_op_wr ? i_wrram : i_rdram;
  always_ff @(posedge i_clk)
    if (!i_reset_n) r_state <= S_IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: w_next = (i_wrram || i_rdram) ? S_WAIT : S_IDLE;
      S_WAIT: w_next = (r_cnt == 4'd0) ? S_ACK : S_WAIT;
      S_ACK:  w_next = S_REL;
      S_REL:  w_next = w_req ? S_REL : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end
  always_comb begin
    o_ram_ack = r_state == S_ACK;
    o_busy    = r_state != S_IDLE;
  end
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_op_wr  <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_cnt    <= '0;
      r_rdata  <= '0;
      r_rd_cnt <= '0;
      r_wr_cnt <= '0;
    end else begin
      // write wins when both requests are high; the read stays pending
      if (r_state == S_IDLE && (i_wrram || i_rdram)) begin
        r_op_wr <= i_wrram;
        r_addr  <= i_addr[MEM_AW-1:0];
        r_wdata <= i_wdata;
        r_cnt   <= 4'(LATENCY - 1);
      end else if (r_state == S_WAIT && r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
      // fill line is loaded on the edge entering ACK so it is visible with the ack
      if (r_state == S_WAIT && r_cnt == 4'd0 && !r_op_wr) r_rdata <= r_mem[r_addr];
      if (r_state == S_ACK && r_op_wr && r_wr_cnt != 16'hFFFF) r_wr_cnt <= r_wr_cnt + 16'd1;
      if (r_state == S_ACK && !r_op_wr && r_rd_cnt != 16'hFFFF) r_rd_cnt <= r_rd_cnt + 16'd1;
    end
  end
  // storage is never cleared; a reset in the ACK cycle suppresses the write
  always_ff @(posedge i_clk)
    if (i_reset_n && r_state == S_ACK && r_op_wr) r_mem[r_addr] <= r_wdata;
  assign o_rdata  = r_rdata;
  assign o_rd_cnt = r_rd_cnt;
  assign o_wr_cnt = r_wr_cnt;
endmodule

// File: tb/tb_ram_responder.sv
// tb_ram_responder: scoreboard bench for ram_responder.
module tb_ram_responder;
  localparam int LAT = 3;
  logic        i_clk = 1'b0;
  logic        i_reset_n = 1'b0;
  logic        i_rdram = 1'b0;
  logic        i_wrram = 1'b0;
  logic [13:0] i_addr = '0;
  logic [63:0] i_wdata = '0;
  logic [63:0] o_rdata;
  logic        o_ram_ack;
  logic        o_busy;
  logic [15:0] o_rd_cnt, o_wr_cnt;
  int          checks = 0;
  int          failures = 0;
  logic [63:0] sb [$];
  logic [63:0] mem_model [256];
  logic [63:0] last_rd = '0;
  int          rd_model = 0;
  int          wr_model = 0;
  ram_responder #(.ADDR_W(14), .MEM_AW(8), .DATA_W(64), .LATENCY(LAT)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_rdram(i_rdram), .i_wrram(i_wrram),
    .i_addr(i_addr), .i_wdata(i_wdata), .o_rdata(o_rdata), .o_ram_ack(o_ram_ack),
    .o_busy(o_busy), .o_rd_cnt(o_rd_cnt), .o_wr_cnt(o_wr_cnt)
  );
  always #5 i_clk = ~i_clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge i_clk);
    #2;
  endtask
  // every ack pops the expected fill-line value pushed when its request was driven
  always @(negedge i_clk)
    if (i_reset_n && o_ram_ack) begin
      if (sb.size() == 0) chk("spurious_ack", 64'd1, 64'd0);
      else chk("sb_rdata", o_rdata, sb.pop_front());
    end
  function automatic logic [63:0] model(input bit wr, input logic [13:0] a, input logic [63:0] d);
    if (wr) begin
      mem_model[a[7:0]] = d;
      wr_model++;
    end else begin
      last_rd = mem_model[a[7:0]];
      rd_model++;
    end
    return last_rd;
  endfunction
  task automatic wait_ack(input string tag, input int exp_lat);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!o_ram_ack && n < 20);
    chk(tag, 64'(n), 64'(exp_lat));
  endtask
  task automatic finish_req();
    i_wrram = 1'b0;
    i_rdram = 1'b0;
    tick();
    chk("ack_width", 64'(o_ram_ack), 64'd0);
    chk("busy_rel", 64'(o_busy), 64'd1);
    tick();
    chk("busy_idle", 64'(o_busy), 64'd0);
    chk("rd_cnt", 64'(o_rd_cnt), 64'(rd_model));
    chk("wr_cnt", 64'(o_wr_cnt), 64'(wr_model));
  endtask
  task automatic txn(input bit wr, input logic [13:0] a, input logic [63:0] d, input bit early);
    sb.push_back(model(wr, a, d));
    i_addr = a;
    i_wdata = d;
    if (wr) i_wrram = 1'b1;
    else i_rdram = 1'b1;
    tick();
    chk("busy_accept", 64'(o_busy), 64'd1);
    // a request dropped during WAIT must still complete
    if (early) begin
      i_wrram = 1'b0;
      i_rdram = 1'b0;
      i_addr = 14'h3FFF;
    end
    wait_ack("latency", LAT);
    finish_req();
  endtask
  initial begin
    repeat (2) tick();
    i_reset_n = 1'b1;
    repeat (5) tick();
    chk("rst_ack", 64'(o_ram_ack), 64'd0);
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_rdata", o_rdata, 64'd0);
    chk("rst_rd_cnt", 64'(o_rd_cnt), 64'd0);
    chk("rst_wr_cnt", 64'(o_wr_cnt), 64'd0);
    txn(1'b1, 14'h0040, 64'h555, 1'b0);
    txn(1'b0, 14'h0040, 64'h0, 1'b0);
    chk("raw_rdata", o_rdata, 64'h555);
    // simultaneous requests: write first, read stays pending
    sb.push_back(model(1'b1, 14'h0080, 64'hFFF));
    sb.push_back(model(1'b0, 14'h0080, 64'h0));
    i_addr = 14'h0080;
    i_wdata = 64'hFFF;
    i_wrram = 1'b1;
    i_rdram = 1'b1;
    tick();
    wait_ack("both_wr_lat", LAT);
    i_wrram = 1'b0;
    tick();
    chk("both_wr_cnt", 64'(o_wr_cnt), 64'(wr_model));
    chk("both_rd_cnt_pending", 64'(o_rd_cnt), 64'(rd_model - 1));
    wait_ack("both_rd_wait", 5);
    chk("both_rdata", o_rdata, 64'hFFF);
    finish_req();
    // request held past ack gives no second ack
    sb.push_back(model(1'b0, 14'h0040, 64'h0));
    i_addr = 14'h0040;
    i_rdram = 1'b1;
    tick();
    wait_ack("hold_lat", LAT);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("hold_ack", 64'(o_ram_ack), 64'd0);
      chk("hold_busy", 64'(o_busy), 64'd1);
    end
    i_rdram = 1'b0;
    tick();
    chk("hold_release", 64'(o_busy), 64'd0);
    // reset during WAIT aborts the write
    txn(1'b1, 14'h0100, 64'h1234, 1'b0);
    i_addr = 14'h0100;
    i_wdata = 64'hDEAD;
    i_wrram = 1'b1;
    tick();
    i_reset_n = 1'b0;
    tick();
    i_reset_n = 1'b1;
    i_wrram = 1'b0;
    rd_model = 0;
    wr_model = 0;
    last_rd = '0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("abort_ack", 64'(o_ram_ack), 64'd0);
    end
    chk("abort_busy", 64'(o_busy), 64'd0);
    chk("abort_rd_cnt", 64'(o_rd_cnt), 64'd0);
    chk("abort_wr_cnt", 64'(o_wr_cnt), 64'd0);
    chk("abort_rdata", o_rdata, 64'd0);
    txn(1'b0, 14'h0100, 64'h0, 1'b0);
    chk("abort_mem", o_rdata, 64'h1234);
    txn(1'b1, 14'h0001, 64'hAB, 1'b0);
    txn(1'b0, 14'h0101, 64'h0, 1'b0);
    chk("alias_rdata", o_rdata, 64'hAB);
    txn(1'b1, 14'h0022, 64'hCAFE_F00D_0000_0001, 1'b1);
    txn(1'b0, 14'h0022, 64'h0, 1'b1);
    chk("early_drop_rdata", o_rdata, 64'hCAFE_F00D_0000_0001);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ram_responder.md
Name: ram_responder

Overview:
- RAM-side responder for the cache controller's line-fill / write-back interface (rdram, wrram, ram_ack, 64-bit line data).
- Models the backing memory: accepts one line read or line write at a time, waits a programmable latency, then returns a one-cycle ram_ack.
- On reads it drives the fill line to the cache data path.
- Used as the memory end in cache system simulation; synthesizable for FPGA bring-up.

Parameters:
- ADDR_W, 14, width of the line address from the cache (tag+index).
- MEM_AW, 8, implemented storage depth is 2^MEM_AW lines; the address is taken modulo the depth (addr[MEM_AW-1:0]).
- DATA_W, 64, line width.
- LATENCY, 3, cycles from request acceptance to ram_ack; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- rdram  in  1  line read request, level; held until ram_ack.
- wrram  in  1  line write request, level; held until ram_ack.
- addr  in  ADDR_W  line address; sampled at acceptance.
- wdata  in  DATA_W  write-back line; sampled at acceptance.
- rdata  out  DATA_W  fill line; valid in the ram_ack cycle, held until the next read completes.
- ram_ack  out  1  one-cycle completion pulse.
- busy  out  1  high from acceptance through the release of the request.
- rd_cnt  out  16  completed reads, saturating at 16'hFFFF.
- wr_cnt  out  16  completed writes, saturating at 16'hFFFF.

Behaviour:
- Reset (reset_n=0 at a rising edge):
  - state=IDLE; ram_ack=0, busy=0, rdata=0, rd_cnt=0, wr_cnt=0; latency counter cleared.
  - Storage array is not cleared.
  - Reset mid-transaction aborts it: no ack, no memory write.
- States:
  - IDLE:
    - wrram=1 → capture addr/wdata, op=WR, load cnt=LATENCY-1, go WAIT.
    - Else rdram=1 → capture addr, op=RD, same load, go WAIT.
    - Else stay.
    - Write has priority when both are high; the read stays pending.
  - WAIT:
    - cnt decrements each cycle.
    - At cnt==0 go ACK.
    - With LATENCY=1, ACK follows acceptance directly.
  - ACK (one cycle):
    - ram_ack=1.
    - WR: mem[addr_q]<=wdata_q; wr_cnt++.
    - RD: rdata<=mem[addr_q], visible in this cycle (registered at the ACK entry edge); rd_cnt++.
    - Go REL.
  - REL:
    - ram_ack=0; wait until the request line of the serviced op is low, then IDLE.
    - The other request line may stay high; it is serviced from IDLE next.
- Timing: request seen high at edge k → ram_ack high for the cycle following edge k+LATENCY. Exactly one ack per accepted request.
- busy=1 in WAIT, ACK and REL.
- Request lines and addr changes during WAIT/ACK/REL are ignored (captured copies are used).
- Read of a location written earlier returns the written line (read-after-write, including the immediately following transaction).
- Aliasing: addresses equal modulo 2^MEM_AW map to the same line.
- Counters saturate; no wrap.
- A request that drops before acceptance is never serviced.
- A request that drops during WAIT is still completed and acked.

Test Plan:
- Reset then idle 5 cycles → ram_ack=0, busy=0, rdata=0, counters 0.
- wrram=1, addr=14'h0040, wdata=64'h0000_0000_0000_0555, held until ack, LATENCY=3 → ram_ack pulse exactly 3 cycles after acceptance, width 1; wr_cnt=1. Then rdram addr=14'h0040 → rdata=64'h555 in the ack cycle; rd_cnt=1.
- wrram and rdram both asserted, addr=14'h0080, wdata=64'hFFF; wrram dropped after first ack, rdram held → first ack is the write; second ack returns rdata=64'hFFF; wr_cnt=1, rd_cnt=1.
- Request held high 4 cycles past ack → no second ack; busy stays 1 until drop, then 0 the next cycle.
- reset_n pulsed low during WAIT of a write to addr 14'h0100 → no ack; a later read of 14'h0100 returns the previous contents; counters 0.
- Write 64'hAB to addr 14'h0001, read addr 14'h0101 (MEM_AW=8) → rdata=64'hAB (aliasing).
